gate_seq_ctrl: RTL and testbench
================================

Name: gate_seq_ctrl

Overview:
Sequencer that drives the five-input gate network (y = ((a & b) ^ (c | d)) | e) and captures its response.
- Sweep mode: applies all 32 input vectors in order and builds a 32-bit truth table.
- Single mode: applies one vector.
- An internal golden model checks every sample and counts mismatches.
- Sits between a test/config master (start/done handshake) and the gate network's inputs and output.

Parameters:
SETTLE_CYC, 1, extra cycles a vector is held before sampling (legal 0..15); each vector occupies SETTLE_CYC+1 cycles.

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_start  input  1  start request; accepted only in IDLE
i_mode  input  1  0 = sweep 0..31, 1 = single vector
i_vec  input  5  vector for single mode, captured at accepted start; bit4..0 = a,b,c,d,e
i_gate_y  input  1  gate network output
o_gate_a  output  1  drive to gate input a (vector bit 4)
o_gate_b  output  1  vector bit 3
o_gate_c  output  1  vector bit 2
o_gate_d  output  1  vector bit 1
o_gate_e  output  1  vector bit 0
o_busy  output  1  high while a run is in progress
o_done  output  1  one-cycle pulse at end of run
o_table  output  32  captured truth table; bit k = i_gate_y sampled for vector k
o_err_cnt  output  6  mismatches vs golden model in current/last run (0..32)
o_mismatch  output  1  sticky: at least one mismatch since last accepted start

Behaviour:
- Clock and reset:
  - One clock domain, i_clk. i_rst synchronous, active-high, takes priority over everything.
  - Reset values: all outputs 0, o_table = 0, state IDLE.
  - Reset mid-run aborts the run; no o_done is issued.
- All outputs are registered. o_gate_* = 0 whenever state is IDLE.
- States: IDLE, APPLY, SAMPLE.
- IDLE:
  - On i_start=1, the start is accepted: o_busy <= 1, o_err_cnt <= 0, o_mismatch <= 0.
  - Vector register <= 0 (sweep) or i_vec (single).
  - Settle counter <= SETTLE_CYC. Next state: APPLY (or SAMPLE directly if SETTLE_CYC = 0).
  - Sweep mode also clears o_table. Single mode retains o_table except the addressed bit.
- APPLY: vector held on o_gate_*; counter decrements each cycle; at 1 -> SAMPLE.
- SAMPLE (one cycle, vector still driven):
  - o_table[vec] <= i_gate_y.
  - Golden model computed internally from the vector register. If it differs from i_gate_y: o_err_cnt += 1 and o_mismatch <= 1.
  - If not last (sweep, vec < 31): vec += 1, counter reloaded, -> APPLY (or SAMPLE if SETTLE_CYC = 0).
  - If last (sweep vec = 31, or single mode): -> IDLE, o_busy <= 0, o_done <= 1 for exactly one cycle.
- Timing, with the accepting edge = edge 0:
  - Vector k is visible after edge k*(S+1) and sampled at edge (k+1)*(S+1).
  - Sweep: o_busy high after edge 0 through edge 32*(S+1). o_done high in the cycle after edge 32*(S+1).
  - Single: o_done after edge S+1.
  - o_busy falls in the same cycle o_done rises.
- Boundaries and simultaneous events:
  - Vector index never wraps past 31.
  - i_start while busy is ignored and not queued.
  - i_start in the same cycle as the o_done pulse is ignored, because state is still SAMPLE at that edge. A new start is accepted from the following cycle.
  - o_err_cnt cannot exceed 32, so no overflow.
  - i_mode and i_vec are sampled only at the accepting edge; later changes have no effect.
  - o_table, o_err_cnt and o_mismatch hold their values in IDLE until the next start or reset.

Test Plan:
1. SETTLE_CYC=1, correct gate attached, sweep -> o_table = 32'hABFE_FEFE, o_err_cnt = 0, o_mismatch = 0; o_done one cycle after edge 64; o_busy high for 64 cycles.
2. i_gate_y stuck 0, sweep -> o_table = 0, o_err_cnt = 26, o_mismatch = 1. Stuck 1 -> o_table = 32'hFFFF_FFFF, o_err_cnt = 6.
3. After test 1, single mode i_vec = 5'b11000 with i_gate_y forced 0 -> o_table bit 24 = 0, other bits unchanged (32'hAAFE_FEFE); o_err_cnt = 1; o_done after edge 2.
4. Reset asserted at edge 20 of a sweep -> all outputs 0 the next cycle, no o_done. Fresh sweep then completes normally.
5. i_start pulsed during a sweep and again in the o_done cycle -> both ignored. Start one cycle later -> new run begins with o_err_cnt cleared.
6. SETTLE_CYC=0 and SETTLE_CYC=3 builds -> each vector held 1 / 4 cycles; sweep o_done at edge 32 / 128; o_table = 32'hABFE_FEFE.

Source files
------------

// File: rtl/gate_seq_ctrl.sv
// Sequencer for the five-input gate network y = ((a & b) ^ (c | d)) | e.
// Drives one vector or all 32 vectors onto the network. Each response is
// recorded in a truth table and checked against an internal golden model.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no run in progress, gate inputs driven low, waiting for i_start
// ST_APPLY  | vector held on the gate inputs while the settle counter runs down
// ST_SAMPLE | vector still driven; i_gate_y captured and checked this cycle
module gate_seq_ctrl #(
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_mode,
  input  logic [4:0]  i_vec,
  input  logic        i_gate_y,
  output logic        o_gate_a,
  output logic        o_gate_b,
  output logic        o_gate_c,
  output logic        o_gate_d,
  output logic        o_gate_e,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_table,
  output logic [5:0]  o_err_cnt,
  output logic        o_mismatch
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);
  localparam bit         NO_SETTLE = (SETTLE_CYC == 0);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic [4:0] vec;
  logic       mode_single;
  logic       accept;
  logic       do_sample;
  logic       last_vec;
  logic       gold_y;

  // Reference response of a healthy gate network for the vector being driven.
  assign gold_y = ((vec[4] & vec[3]) ^ (vec[2] | vec[1])) | vec[0];

  // The vector register is zero outside a run, so it drives the gate pins directly.
  assign o_gate_a = vec[4];
  assign o_gate_b = vec[3];
  assign o_gate_c = vec[2];
  assign o_gate_d = vec[1];
  assign o_gate_e = vec[0];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the accept/sample/last strobes used by the datapath.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    do_sample = 1'b0;
    last_vec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = NO_SETTLE ? ST_SAMPLE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (settle_cnt <= 4'd1) begin
          state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        do_sample = 1'b1;
        last_vec  = mode_single || (vec == 5'd31);
        if (last_vec) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = NO_SETTLE ? ST_SAMPLE : ST_APPLY;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Run bookkeeping: vector stepping, settle timer, truth table and error tally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_cnt  <= 4'd0;
      vec         <= 5'd0;
      mode_single <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_table     <= 32'd0;
      o_err_cnt   <= 6'd0;
      o_mismatch  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (accept) begin
        o_busy      <= 1'b1;
        o_err_cnt   <= 6'd0;
        o_mismatch  <= 1'b0;
        mode_single <= i_mode;
        settle_cnt  <= SETTLE_LD;
        vec         <= i_mode ? i_vec : 5'd0;
        if (!i_mode) begin
          o_table <= 32'd0;
        end
      end else if (state == ST_APPLY) begin
        settle_cnt <= settle_cnt - 4'd1;
      end else if (do_sample) begin
        o_table[vec] <= i_gate_y;
        if (i_gate_y != gold_y) begin
          o_err_cnt  <= o_err_cnt + 6'd1;
          o_mismatch <= 1'b1;
        end
        if (last_vec) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
          vec    <= 5'd0;
        end else begin
          vec        <= vec + 5'd1;
          settle_cnt <= SETTLE_LD;
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Bench for gate_seq_ctrl: three builds (settle 0, 1, 3) run side by side
// against an environment gate that is healthy, stuck at 0 or stuck at 1.
// A run-level model predicts every output each cycle.
module tb_gate_seq_ctrl;

  localparam int SARR [3] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [4:0]  vin = 5'd0;
  int          fault = 0;     // 0 healthy, 1 stuck 0, 2 stuck 1

  logic [2:0]  busy, done, mis, gy;
  logic [4:0]  gv  [3];
  logic [31:0] tab [3];
  logic [5:0]  err [3];

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  int ecnt = 0;
  int e0 = 0;

  // model state per instance
  bit          m_act  [3];
  bit          m_done [3];
  bit          m_mis  [3];
  bit          m_sweep[3];
  int          m_n    [3];
  int          m_len  [3];
  int          m_err  [3];
  logic [4:0]  m_vec  [3];
  logic [31:0] m_tab  [3];

  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [4:0] v);
    return ((v[4] & v[3]) ^ (v[2] | v[1])) | v[0];
  endfunction

  function automatic logic env_y(input logic [4:0] v, input int f);
    if (f == 1) return 1'b0;
    if (f == 2) return 1'b1;
    return gate_fn(v);
  endfunction

  assign gy[0] = env_y(gv[0], fault);
  assign gy[1] = env_y(gv[1], fault);
  assign gy[2] = env_y(gv[2], fault);

  gate_seq_ctrl #(.SETTLE_CYC(0)) u_s0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_vec(vin),
    .i_gate_y(gy[0]),
    .o_gate_a(gv[0][4]), .o_gate_b(gv[0][3]), .o_gate_c(gv[0][2]),
    .o_gate_d(gv[0][1]), .o_gate_e(gv[0][0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_table(tab[0]),
    .o_err_cnt(err[0]), .o_mismatch(mis[0])
  );

  gate_seq_ctrl #(.SETTLE_CYC(1)) u_s1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_vec(vin),
    .i_gate_y(gy[1]),
    .o_gate_a(gv[1][4]), .o_gate_b(gv[1][3]), .o_gate_c(gv[1][2]),
    .o_gate_d(gv[1][1]), .o_gate_e(gv[1][0]),
    .o_busy(busy[1]), .o_done(done[1]), .o_table(tab[1]),
    .o_err_cnt(err[1]), .o_mismatch(mis[1])
  );

  gate_seq_ctrl #(.SETTLE_CYC(3)) u_s3 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_vec(vin),
    .i_gate_y(gy[2]),
    .o_gate_a(gv[2][4]), .o_gate_b(gv[2][3]), .o_gate_c(gv[2][2]),
    .o_gate_d(gv[2][1]), .o_gate_e(gv[2][0]),
    .o_busy(busy[2]), .o_done(done[2]), .o_table(tab[2]),
    .o_err_cnt(err[2]), .o_mismatch(mis[2])
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[S=%0d] t=%0t got=%h want=%h", nm, SARR[idx], $time, act, exp);
    end
  endtask

  // Run-level model: a run is a count of edges since the accept; every
  // (S+1)-th edge samples one vector, and the run ends at the last sample.
  int   mk;
  logic my;
  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 0; m_done[i] = 0; m_mis[i] = 0; m_n[i] = 0;
        m_err[i] = 0; m_tab[i] = '0; m_vec[i] = '0;
      end else begin
        m_done[i] = 0;
        if (m_act[i]) begin
          m_n[i]++;
          if (m_n[i] % (SARR[i] + 1) == 0) begin
            mk = m_sweep[i] ? (m_n[i] / (SARR[i] + 1) - 1) : int'(m_vec[i]);
            my = env_y(5'(mk), fault);
            m_tab[i][mk] = my;
            if (my != gate_fn(5'(mk))) begin
              m_err[i]++;
              m_mis[i] = 1;
            end
            if (m_n[i] == m_len[i]) begin
              m_act[i]  = 0;
              m_done[i] = 1;
            end
          end
        end else if (start) begin
          m_act[i]   = 1;
          m_n[i]     = 0;
          m_sweep[i] = !mode;
          m_vec[i]   = vin;
          m_err[i]   = 0;
          m_mis[i]   = 0;
          if (!mode) m_tab[i] = '0;
          m_len[i]   = mode ? (SARR[i] + 1) : 32 * (SARR[i] + 1);
        end
      end
    end
  end

  function automatic logic [4:0] exp_gate(input int i);
    if (!m_act[i]) return 5'd0;
    if (m_sweep[i]) return 5'(m_n[i] / (SARR[i] + 1));
    return m_vec[i];
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, 32'(busy[i]), 32'(m_act[i]));
        chk("done", i, 32'(done[i]), 32'(m_done[i]));
        chk("gate", i, 32'(gv[i]), 32'(exp_gate(i)));
        chk("table", i, tab[i], m_tab[i]);
        chk("err_cnt", i, 32'(err[i]), 32'(m_err[i]));
        chk("mismatch", i, 32'(mis[i]), 32'(m_mis[i]));
      end
    end
  end

  // Pulse start for one cycle; ends at the negedge after the accepting edge.
  task automatic kick(input logic m, input logic [4:0] v);
    @(negedge clk);
    start = 1'b1; mode = m; vin = v;
    @(posedge clk);
    #1 e0 = ecnt;
    @(negedge clk);
    start = 1'b0; mode = ~m; vin = ~v;
  endtask

  task automatic wait_done(input int idx, input int exp_lat);
    for (int c = 0; c < 400 && !done[idx]; c++) @(negedge clk);
    if (!done[idx]) begin
      total++; bad++;
      $display("FAIL done_timeout[S=%0d] got=no_done want=done", SARR[idx]);
    end else begin
      chk("done_latency", idx, 32'(ecnt - e0), 32'(exp_lat));
    end
  endtask

  task automatic wait_edges(input int n);
    for (int c = 0; c < 500 && (ecnt - e0) < n; c++) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 400 && busy != 3'b000; c++) @(negedge clk);
    if (busy != 3'b000) begin
      total++; bad++;
      $display("FAIL idle_timeout got=%b want=000", busy);
    end
  endtask

  task automatic sweep_all(input int f);
    fault = f;
    kick(1'b0, 5'd0);
    wait_done(0, 32);
    wait_done(1, 64);
    wait_done(2, 128);
    wait_idle();
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 1, 32'(busy[1]), 32'd0);
    chk("rst_table", 1, tab[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // healthy sweep, all settle builds
    sweep_all(0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_table", i, tab[i], 32'hABFE_FEFE);
      chk("t1_err", i, 32'(err[i]), 32'd0);
    end

    // single vector 24 against a stuck-0 gate
    fault = 1;
    kick(1'b1, 5'b11000);
    wait_done(0, 1);
    wait_done(1, 2);
    wait_done(2, 4);
    wait_idle();
    chk("t3_table", 1, tab[1], 32'hAAFE_FEFE);
    chk("t3_err", 1, 32'(err[1]), 32'd1);
    chk("t3_mis", 1, 32'(mis[1]), 32'd1);

    // stuck-at sweeps
    sweep_all(1);
    chk("t2_s0_table", 1, tab[1], 32'd0);
    chk("t2_s0_err", 1, 32'(err[1]), 32'd26);
    chk("t2_s0_mis", 1, 32'(mis[1]), 32'd1);
    sweep_all(2);
    chk("t2_s1_table", 1, tab[1], 32'hFFFF_FFFF);
    chk("t2_s1_err", 1, 32'(err[1]), 32'd6);

    // reset taken at edge 20 of a sweep
    fault = 0;
    kick(1'b0, 5'd0);
    wait_edges(19);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_busy", 1, 32'(busy[1]), 32'd0);
    chk("t4_table", 1, tab[1], 32'd0);
    chk("t4_gate", 1, 32'(gv[1]), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sweep_all(0);
    chk("t4_table_after", 1, tab[1], 32'hABFE_FEFE);

    // starts while busy and at the finishing edge are ignored
    fault = 2;
    kick(1'b0, 5'd0);
    wait_edges(10);
    start = 1'b1; mode = 1'b1; vin = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_edges(63);
    start = 1'b1; mode = 1'b1; vin = 5'd0;
    @(negedge clk);
    chk("t5_done", 1, 32'(done[1]), 32'd1);
    mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t5_busy", 1, 32'(busy[1]), 32'd1);
    chk("t5_err_clr", 1, 32'(err[1]), 32'd0);
    chk("t5_mis_clr", 1, 32'(mis[1]), 32'd0);
    wait_idle();
    chk("t5_table", 1, tab[1], 32'hFFFF_FFFF);
    chk("t5_err", 1, 32'(err[1]), 32'd6);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
